// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32IM instruction decode stage
//
// Purpose: accepts one instruction word + PC per valid/ready handshake,
// decodes register indices, function fields, the sign-extended immediate and
// the instruction format, and presents the result one cycle later. Supports
// backpressure, flush, and a saturating count of accepted instructions.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   flush             drops the held entry and any same-cycle input
//   in_valid/in_ready upstream handshake; in_inst, in_pc payload
//   out_valid/out_ready downstream handshake
//   out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_func3, out_func7,
//   out_imm, out_fmt, out_illegal   registered decode result
//   dec_count         saturating count of accepted instructions
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int M_EXT = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_func3,
  output logic [6:0]       out_func7,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_count
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_SYS = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // Registered outputs
  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [6:0]       r_opcode;
  logic [4:0]       r_rd;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [2:0]       r_func3;
  logic [6:0]       r_func7;
  logic [XLEN-1:0]  r_imm;
  logic [2:0]       r_fmt;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  // Combinational decode of the incoming word
  logic [6:0]         w_op;
  logic [2:0]         w_fmt;
  logic               w_f7_legal;
  logic [6:0]         w_opcode;
  logic [4:0]         w_rd;
  logic [4:0]         w_rs1;
  logic [4:0]         w_rs2;
  logic [2:0]         w_func3;
  logic [6:0]         w_func7;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]    w_imm;
  logic               w_accept;

  assign w_op = in_inst[6:0];

  // MUL/DIV func7 is only legal when the M extension is built in.
  assign w_f7_legal = (in_inst[31:25] == 7'b0000000) ||
                      (in_inst[31:25] == 7'b0100000) ||
                      ((M_EXT != 0) && (in_inst[31:25] == 7'b0000001));

  always_comb begin
    w_fmt    = FMT_ILL;
    w_opcode = 7'd0;
    w_rd     = 5'd0;
    w_rs1    = 5'd0;
    w_rs2    = 5'd0;
    w_func3  = 3'd0;
    w_func7  = 7'd0;
    w_imm32  = 32'sd0;

    case (w_op)
      7'b0110011:                         w_fmt = w_f7_legal ? FMT_R : FMT_ILL;
      7'b0010011, 7'b0000011, 7'b1100111: w_fmt = FMT_I;
      7'b0100011:                         w_fmt = FMT_S;
      7'b1100011:                         w_fmt = FMT_B;
      7'b0110111, 7'b0010111:             w_fmt = FMT_U;
      7'b1101111:                         w_fmt = FMT_J;
      7'b1110011:                         w_fmt = FMT_SYS;
      default:                            w_fmt = FMT_ILL;
    endcase

    // Illegal entries leave every field except pc/fmt/illegal at zero.
    if (w_fmt != FMT_ILL) w_opcode = w_op;

    case (w_fmt)
      FMT_R: begin
        w_rd    = in_inst[11:7];
        w_rs1   = in_inst[19:15];
        w_rs2   = in_inst[24:20];
        w_func3 = in_inst[14:12];
        w_func7 = in_inst[31:25];
      end
      FMT_I: begin
        w_rd    = in_inst[11:7];
        w_rs1   = in_inst[19:15];
        w_func3 = in_inst[14:12];
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      FMT_SYS: begin
        w_rd    = in_inst[11:7];
        w_rs1   = in_inst[19:15];
        w_func3 = in_inst[14:12];
      end
      FMT_S: begin
        w_rs1   = in_inst[19:15];
        w_rs2   = in_inst[24:20];
        w_func3 = in_inst[14:12];
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      FMT_B: begin
        w_rs1   = in_inst[19:15];
        w_rs2   = in_inst[24:20];
        w_func3 = in_inst[14:12];
        w_imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
      end
      FMT_U: begin
        w_rd    = in_inst[11:7];
        w_imm32 = {in_inst[31:12], 12'd0};
      end
      FMT_J: begin
        w_rd    = in_inst[11:7];
        w_imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
      end
      default: begin
      end
    endcase
  end

  // Signed size cast sign-extends the 32-bit immediate to XLEN.
  assign w_imm = XLEN'(w_imm32);

  assign in_ready = !r_valid || out_ready || flush;
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_opcode  <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_func3   <= '0;
      r_func7   <= '0;
      r_imm     <= '0;
      r_fmt     <= '0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_pc      <= in_pc;
      r_opcode  <= w_opcode;
      r_rd      <= w_rd;
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_func3   <= w_func3;
      r_func7   <= w_func7;
      r_imm     <= w_imm;
      r_fmt     <= w_fmt;
      r_illegal <= (w_fmt == FMT_ILL);
      if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_opcode  = r_opcode;
  assign out_rd      = r_rd;
  assign out_rs1     = r_rs1;
  assign out_rs2     = r_rs2;
  assign out_func3   = r_func3;
  assign out_func7   = r_func7;
  assign out_imm     = r_imm;
  assign out_fmt     = r_fmt;
  assign out_illegal = r_illegal;
  assign dec_count   = r_count;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } dec_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_ready;

  // dut1: M_EXT=1, CNT_W=16
  logic        rdy1, v1, ill1;
  logic [31:0] pc1, imm1;
  logic [6:0]  op1, f71;
  logic [4:0]  rd1, rs11, rs21;
  logic [2:0]  f31, fmt1;
  logic [15:0] cnt1;
  // dut2: M_EXT=0, CNT_W=2
  logic        rdy2, v2, ill2;
  logic [31:0] pc2, imm2;
  logic [6:0]  op2, f72;
  logic [4:0]  rd2, rs12, rs22;
  logic [2:0]  f32, fmt2;
  logic [1:0]  cnt2;

  dec_t a1, a2;
  assign a1 = {pc1, op1, rd1, rs11, rs21, f31, f71, imm1, fmt1, ill1};
  assign a2 = {pc2, op2, rd2, rs12, rs22, f32, f72, imm2, fmt2, ill2};

  int n_tests = 0;
  int n_fail  = 0;

  decode_stage #(.XLEN(32), .M_EXT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(v1), .out_ready(out_ready),
    .out_pc(pc1), .out_opcode(op1), .out_rd(rd1), .out_rs1(rs11), .out_rs2(rs21),
    .out_func3(f31), .out_func7(f71), .out_imm(imm1), .out_fmt(fmt1),
    .out_illegal(ill1), .dec_count(cnt1)
  );

  decode_stage #(.XLEN(32), .M_EXT(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(v2), .out_ready(out_ready),
    .out_pc(pc2), .out_opcode(op2), .out_rd(rd2), .out_rs1(rs12), .out_rs2(rs22),
    .out_func3(f32), .out_func7(f72), .out_imm(imm2), .out_fmt(fmt2),
    .out_illegal(ill2), .dec_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] legal_ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                                 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};

  // Reference decode from the ISA rules, immediates built arithmetically.
  function automatic dec_t ref_decode(logic [31:0] i, logic [31:0] pc, bit mext);
    dec_t d;
    int   si;
    int   f;
    logic use_rd, use_rs1, use_rs2, use_f3;
    d = '0;
    d.pc = pc;
    si = i;
    case (i[6:0])
      7'h33:               f = 0;
      7'h13, 7'h03, 7'h67: f = 1;
      7'h23:               f = 2;
      7'h63:               f = 3;
      7'h37, 7'h17:        f = 4;
      7'h6F:               f = 5;
      7'h73:               f = 6;
      default:             f = 7;
    endcase
    if (f == 0 && !(i[31:25] == 7'h00 || i[31:25] == 7'h20 || (mext && i[31:25] == 7'h01)))
      f = 7;
    d.fmt = 3'(f);
    if (f == 7) begin
      d.illegal = 1'b1;
      return d;
    end
    d.opcode = i[6:0];
    use_rd  = (f == 0 || f == 1 || f == 4 || f == 5 || f == 6);
    use_rs1 = (f == 0 || f == 1 || f == 2 || f == 3 || f == 6);
    use_rs2 = (f == 0 || f == 2 || f == 3);
    use_f3  = use_rs1;
    if (use_rd)  d.rd  = i[11:7];
    if (use_rs1) d.rs1 = i[19:15];
    if (use_rs2) d.rs2 = i[24:20];
    if (use_f3)  d.func3 = i[14:12];
    if (f == 0)  d.func7 = i[31:25];
    case (f)
      1: d.imm = 32'(si >>> 20);
      2: d.imm = 32'((si >>> 25) * 32 + int'(i[11:7]));
      3: d.imm = 32'((si >>> 31) * 4096 + int'(i[7]) * 2048 +
                     int'(i[30:25]) * 32 + int'(i[11:8]) * 2);
      4: d.imm = 32'(si & 32'hFFFFF000);
      5: d.imm = 32'((si >>> 31) * (1 << 20) + int'(i[19:12]) * 4096 +
                     int'(i[20]) * 2048 + int'(i[30:21]) * 2);
      default: d.imm = 32'd0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 10) w[6:0] = legal_ops[k];
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (v1 !== 1'b0 || v2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b/%b expected 0/0", v1, v2);
    end
    n_tests++;
    if (cnt1 !== 16'd0 || cnt2 !== 2'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d/%0d expected 0/0", cnt1, cnt2);
    end
    n_tests++;
    if (a1 !== dec_t'(0) || rdy1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_fields: got %h rdy=%b expected 0 rdy=1", a1, rdy1);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_addi();
    in_inst = 32'hFFF00093; in_pc = 32'h100; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_tests++;
    if (v1 !== 1'b1 || fmt1 !== 3'd1 || rd1 !== 5'd1 || rs11 !== 5'd0 || f31 !== 3'd0) begin
      n_fail++;
      $display("FAIL addi_fields: got v=%b fmt=%0d rd=%0d rs1=%0d f3=%0d expected 1 1 1 0 0",
               v1, fmt1, rd1, rs11, f31);
    end
    n_tests++;
    if (imm1 !== 32'hFFFFFFFF || pc1 !== 32'h100 || cnt1 !== 16'd1) begin
      n_fail++;
      $display("FAIL addi_imm: got imm=%h pc=%h cnt=%0d expected ffffffff 00000100 1",
               imm1, pc1, cnt1);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    in_inst = 32'h0020A423; in_pc = 32'h200;
    step();
    n_tests++;
    if (v1 !== 1'b1 || fmt1 !== 3'd2 || rs11 !== 5'd1 || rs21 !== 5'd2 || rd1 !== 5'd0 ||
        imm1 !== 32'd8) begin
      n_fail++;
      $display("FAIL b2b_sw: got v=%b fmt=%0d rs1=%0d rs2=%0d rd=%0d imm=%h", v1, fmt1, rs11,
               rs21, rd1, imm1);
    end
    in_inst = 32'hFE000EE3; in_pc = 32'h204;
    step();
    n_tests++;
    if (v1 !== 1'b1 || fmt1 !== 3'd3 || imm1 !== 32'hFFFFFFFC || pc1 !== 32'h204) begin
      n_fail++;
      $display("FAIL b2b_beq: got v=%b fmt=%0d imm=%h pc=%h expected 1 3 fffffffc 204",
               v1, fmt1, imm1, pc1);
    end
    in_inst = 32'hFF9FF0EF; in_pc = 32'h208;
    step();
    in_valid = 1'b0;
    n_tests++;
    if (v1 !== 1'b1 || fmt1 !== 3'd5 || rd1 !== 5'd1 || imm1 !== 32'hFFFFFFF8 ||
        cnt1 !== 16'd3) begin
      n_fail++;
      $display("FAIL b2b_jal: got v=%b fmt=%0d rd=%0d imm=%h cnt=%0d expected 1 5 1 fffffff8 3",
               v1, fmt1, rd1, imm1, cnt1);
    end
  endtask

  task automatic test_mext();
    apply_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    in_inst = 32'h022081B3; in_pc = 32'h300;
    step();
    n_tests++;
    if (fmt1 !== 3'd0 || f71 !== 7'b0000001 || rd1 !== 5'd3 || ill1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_mext1: got fmt=%0d f7=%b rd=%0d ill=%b expected 0 0000001 3 0",
               fmt1, f71, rd1, ill1);
    end
    n_tests++;
    if (v2 !== 1'b1 || ill2 !== 1'b1 || fmt2 !== 3'd7 || imm2 !== 32'd0 || rd2 !== 5'd0 ||
        op2 !== 7'd0 || pc2 !== 32'h300) begin
      n_fail++;
      $display("FAIL mul_mext0: got v=%b ill=%b fmt=%0d imm=%h rd=%0d op=%h pc=%h",
               v2, ill2, fmt2, imm2, rd2, op2, pc2);
    end
    in_inst = 32'h00000000; in_pc = 32'h304;
    step();
    in_valid = 1'b0;
    n_tests++;
    if (ill1 !== 1'b1 || fmt1 !== 3'd7 || op1 !== 7'd0 || pc1 !== 32'h304 || cnt1 !== 16'd2) begin
      n_fail++;
      $display("FAIL zero_illegal: got ill=%b fmt=%0d op=%h pc=%h cnt=%0d expected 1 7 0 304 2",
               ill1, fmt1, op1, pc1, cnt1);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    in_inst = 32'h00730293; in_pc = 32'h400;   // addi x5,x6,7
    step();
    out_ready = 1'b0;
    in_inst = 32'h123453B7; in_pc = 32'h404;   // lui x7,0x12345
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (rdy1 !== 1'b0 || v1 !== 1'b1 || rd1 !== 5'd5 || rs11 !== 5'd6 || imm1 !== 32'd7 ||
          pc1 !== 32'h400 || cnt1 !== 16'd1) begin
        n_fail++;
        $display("FAIL hold_c%0d: got rdy=%b v=%b rd=%0d rs1=%0d imm=%h pc=%h cnt=%0d", c,
                 rdy1, v1, rd1, rs11, imm1, pc1, cnt1);
      end
    end
    out_ready = 1'b1;
    step();
    n_tests++;
    if (v1 !== 1'b1 || fmt1 !== 3'd4 || rd1 !== 5'd7 || imm1 !== 32'h12345000 ||
        pc1 !== 32'h404 || cnt1 !== 16'd2) begin
      n_fail++;
      $display("FAIL release: got v=%b fmt=%0d rd=%0d imm=%h pc=%h cnt=%0d", v1, fmt1, rd1,
               imm1, pc1, cnt1);
    end
  endtask

  task automatic test_flush();
    // Continues from backpressure: lui entry held, count 2.
    out_ready = 1'b0; in_valid = 1'b1; flush = 1'b1;
    in_inst = 32'h00000013; in_pc = 32'h408;
    #1;
    n_tests++;
    if (rdy1 !== 1'b1) begin
      n_fail++; $display("FAIL flush_ready: got %b expected 1", rdy1);
    end
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (v1 !== 1'b0 || v2 !== 1'b0 || cnt1 !== 16'd2) begin
      n_fail++;
      $display("FAIL flush: got v=%b/%b cnt=%0d expected 0/0 2", v1, v2, cnt1);
    end
  endtask

  task automatic test_saturate_and_async_reset();
    apply_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h500;
    repeat (4) step();
    n_tests++;
    if (cnt2 !== 2'd3 || cnt1 !== 16'd4) begin
      n_fail++;
      $display("FAIL saturate: got cnt2=%0d cnt1=%0d expected 3 4", cnt2, cnt1);
    end
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if (v1 !== 1'b0 || v2 !== 1'b0 || cnt1 !== 16'd0 || cnt2 !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b/%b cnt=%0d/%0d expected 0/0 0/0", v1, v2, cnt1, cnt2);
    end
    in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_random();
    dec_t m1, m2;
    logic mv;
    int   mc1, mc2;
    logic acc, exp_rdy;
    apply_reset();
    mv = 1'b0; mc1 = 0; mc2 = 0; m1 = '0; m2 = '0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      in_inst   = rand_inst();
      in_pc     = $urandom & 32'hFFFFFFFC;
      acc = in_valid && (!mv || out_ready) && !flush;
      if (flush) mv = 1'b0;
      else if (acc) begin
        mv = 1'b1;
        m1 = ref_decode(in_inst, in_pc, 1'b1);
        m2 = ref_decode(in_inst, in_pc, 1'b0);
        mc1 = (mc1 < 65535) ? mc1 + 1 : mc1;
        mc2 = (mc2 < 3) ? mc2 + 1 : mc2;
      end else if (out_ready) mv = 1'b0;
      step();
      exp_rdy = !mv || out_ready || flush;
      n_tests++;
      if (v1 !== mv || cnt1 !== 16'(mc1) || (mv && a1 !== m1)) begin
        n_fail++;
        $display("FAIL rand1_c%0d: got v=%b cnt=%0d dec=%h expected v=%b cnt=%0d dec=%h",
                 c, v1, cnt1, a1, mv, mc1, m1);
      end
      n_tests++;
      if (v2 !== mv || cnt2 !== 2'(mc2) || (mv && a2 !== m2)) begin
        n_fail++;
        $display("FAIL rand2_c%0d: got v=%b cnt=%0d dec=%h expected v=%b cnt=%0d dec=%h",
                 c, v2, cnt2, a2, mv, mc2, m2);
      end
      n_tests++;
      if (rdy1 !== exp_rdy || rdy2 !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_ready_c%0d: got %b/%b expected %b", c, rdy1, rdy2, exp_rdy);
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_mext();
    test_backpressure();
    test_flush();
    test_saturate_and_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
